vga_record_ctrl: RTL and testbench

VGA_RECORD_CTRL -- requirements
Module: vga_record_ctrl

---
 rtl/vga_record_if.sv | 28 ++
 rtl/vga_record_ctrl.sv | 150 +++++++++++++++
 tb/tb_vga_record_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_record_if.sv
// Request/digit inputs and record-display outputs of the VGA record controller.
// The master drives the requests and live digits; the slave is the controller.
interface vga_record_if;
    logic       save_req;
    logic       next_req;
    logic       clear_req;
    logic       frame_start;
    logic [3:0] cur_d1, cur_d2, cur_d3, cur_d4, cur_d5, cur_d6, cur_d7;
    logic       has_record;
    logic [3:0] led1, led2, led3, led4, led5, led6, led7;
    logic [2:0] rec_count;
    logic [1:0] rec_index;
    logic       busy;

    modport master (
        output save_req, next_req, clear_req, frame_start,
        output cur_d1, cur_d2, cur_d3, cur_d4, cur_d5, cur_d6, cur_d7,
        input  has_record, rec_count, rec_index, busy,
        input  led1, led2, led3, led4, led5, led6, led7
    );

    modport slave (
        input  save_req, next_req, clear_req, frame_start,
        input  cur_d1, cur_d2, cur_d3, cur_d4, cur_d5, cur_d6, cur_d7,
        output has_record, rec_count, rec_index, busy,
        output led1, led2, led3, led4, led5, led6, led7
    );
endinterface

// File: rtl/vga_record_ctrl.sv
// Captures up to four 7-digit BCD records and shows one at a time for a fixed
// number of VGA frames, with browsing from newest to oldest.
module vga_record_ctrl #(
    parameter int SHOW_FRAMES = 300,
    parameter int DEPTH       = 4
) (
    input logic         clk,
    input logic         rst,
    vga_record_if.slave bus
);
    localparam int FCW = (SHOW_FRAMES > 1) ? $clog2(SHOW_FRAMES + 1) : 1;
    localparam logic [FCW-1:0] LAST_FRAME = FCW'(SHOW_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, SHOW} state_t;

    state_t          state_reg, state_next;
    logic [27:0]     slot_reg [DEPTH];
    logic [27:0]     snap_reg;
    logic [27:0]     led_reg, led_next;
    logic [1:0]      wr_ptr_reg, wr_ptr_next;
    logic [1:0]      rec_index_reg, rec_index_next;
    logic [2:0]      rec_count_reg, rec_count_next;
    logic [FCW-1:0]  frame_cnt_reg, frame_cnt_next;
    logic            snap_load, slot_write, slots_clear;
    logic [27:0]     cur_word, cur_clamped;
    logic [1:0]      step_index, newest, age;

    assign cur_word = {bus.cur_d7, bus.cur_d6, bus.cur_d5, bus.cur_d4,
                       bus.cur_d3, bus.cur_d2, bus.cur_d1};

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_clamp
            assign cur_clamped[gi*4 +: 4] = (cur_word[gi*4 +: 4] > 4'd9) ? 4'd9
                                                                        : cur_word[gi*4 +: 4];
        end
    endgenerate

    // Age of a slot counts back from the newest; a slot is valid if age < rec_count.
    assign step_index = rec_index_reg - 2'd1;
    assign newest     = wr_ptr_reg - 2'd1;
    assign age        = newest - step_index;

    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = wr_ptr_reg;
        rec_index_next = rec_index_reg;
        rec_count_next = rec_count_reg;
        frame_cnt_next = frame_cnt_reg;
        snap_load      = 1'b0;
        slot_write     = 1'b0;
        slots_clear    = 1'b0;
        if (bus.clear_req) begin
            state_next     = IDLE;
            wr_ptr_next    = '0;
            rec_index_next = '0;
            rec_count_next = '0;
            frame_cnt_next = '0;
            slots_clear    = 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.save_req) begin
                        snap_load  = 1'b1;
                        state_next = CAPTURE;
                    end else if (bus.next_req && rec_count_reg != 3'd0) begin
                        state_next     = SHOW;
                        rec_index_next = newest;
                        frame_cnt_next = '0;
                    end
                end
                CAPTURE: begin
                    slot_write     = 1'b1;
                    rec_index_next = wr_ptr_reg;
                    wr_ptr_next    = wr_ptr_reg + 2'd1;
                    rec_count_next = (rec_count_reg == 3'd4) ? 3'd4 : rec_count_reg + 3'd1;
                    frame_cnt_next = '0;
                    state_next     = SHOW;
                end
                SHOW: begin
                    if (bus.save_req) begin
                        snap_load  = 1'b1;
                        state_next = CAPTURE;
                    end else if (bus.next_req) begin
                        rec_index_next = ({1'b0, age} < rec_count_reg) ? step_index : newest;
                        frame_cnt_next = '0;
                    end else if (bus.frame_start) begin
                        if (frame_cnt_reg == LAST_FRAME) begin
                            state_next     = IDLE;
                            frame_cnt_next = '0;
                        end else begin
                            frame_cnt_next = frame_cnt_reg + FCW'(1);
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
        // Look ahead so the new record is on the LEDs as soon as SHOW is entered.
        led_next = '0;
        if (state_next == SHOW) begin
            led_next = (state_reg == CAPTURE) ? snap_reg : slot_reg[rec_index_next];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            snap_reg      <= '0;
            led_reg       <= '0;
            wr_ptr_reg    <= '0;
            rec_index_reg <= '0;
            rec_count_reg <= '0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            led_reg       <= led_next;
            wr_ptr_reg    <= wr_ptr_next;
            rec_index_reg <= rec_index_next;
            rec_count_reg <= rec_count_next;
            frame_cnt_reg <= frame_cnt_next;
            if (snap_load) begin
                snap_reg <= cur_clamped;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst || slots_clear) begin
                    slot_reg[gi] <= '0;
                end else if (slot_write && wr_ptr_reg == 2'(gi)) begin
                    slot_reg[gi] <= snap_reg;
                end
            end
        end
    endgenerate

    assign bus.has_record = (state_reg == SHOW);
    assign bus.busy       = (state_reg == CAPTURE);
    assign bus.rec_count  = rec_count_reg;
    assign bus.rec_index  = rec_index_reg;
    assign bus.led1       = led_reg[3:0];
    assign bus.led2       = led_reg[7:4];
    assign bus.led3       = led_reg[11:8];
    assign bus.led4       = led_reg[15:12];
    assign bus.led5       = led_reg[19:16];
    assign bus.led6       = led_reg[23:20];
    assign bus.led7       = led_reg[27:24];
endmodule

// File: tb/tb_vga_record_ctrl.sv
// Scenario bench for vga_record_ctrl: saves push expected records to a queue,
// which are popped and compared once the record reaches the LEDs.
module tb_vga_record_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [27:0] sb_q [$];
    logic [27:0] model_slots [4];
    int          model_wr = 0;
    int          model_count = 0;

    vga_record_if bus ();

    vga_record_ctrl #(.SHOW_FRAMES(3), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] leds();
        return {bus.led7, bus.led6, bus.led5, bus.led4, bus.led3, bus.led2, bus.led1};
    endfunction

    function automatic logic [27:0] clamp_word(input logic [27:0] w);
        logic [27:0] r;
        for (int i = 0; i < 7; i++) r[i*4 +: 4] = (w[i*4 +: 4] > 4'd9) ? 4'd9 : w[i*4 +: 4];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_digits(input logic [27:0] w);
        {bus.cur_d7, bus.cur_d6, bus.cur_d5, bus.cur_d4, bus.cur_d3, bus.cur_d2, bus.cur_d1} = w;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) model_slots[i] = '0;
        model_wr = 0;
        model_count = 0;
        sb_q.delete();
    endtask

    // Pulses save_req in the current cycle; returns in the CAPTURE cycle.
    task automatic drive_save(input logic [27:0] w);
        set_digits(w);
        bus.save_req = 1'b1;
        sb_q.push_back(clamp_word(w));
        model_slots[model_wr] = clamp_word(w);
        model_wr = (model_wr + 1) % 4;
        if (model_count < 4) model_count++;
        step();
        bus.save_req = 1'b0;
    endtask

    task automatic pulse_next();
        bus.next_req = 1'b1;
        step();
        bus.next_req = 1'b0;
    endtask

    task automatic test_reset();
        set_digits(28'h7654321);
        bus.save_req = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        bus.save_req = 1'b0;
        step();
        checks++; if (bus.has_record !== 1'b0) begin failures++; $display("FAIL reset_has_record got=%b exp=0", bus.has_record); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (leds() !== 28'h0) begin failures++; $display("FAIL reset_leds got=%h exp=0", leds()); end
        checks++; if (bus.rec_count !== 3'd0 || bus.rec_index !== 2'd0) begin failures++; $display("FAIL reset_count_index got=%0d/%0d exp=0/0", bus.rec_count, bus.rec_index); end
        $display("test_reset done");
    endtask

    task automatic test_single_save();
        logic [27:0] exp;
        drive_save(28'h7654321);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL save_busy got=%b exp=1", bus.busy); end
        step();
        checks++; if (bus.has_record !== 1'b1) begin failures++; $display("FAIL save_has_record got=%b exp=1", bus.has_record); end
        checks++; if (sb_q.size() == 0) begin failures++; $display("FAIL save_queue got=empty exp=entry"); end
        else begin
            exp = sb_q.pop_front();
            checks++; if (leds() !== exp) begin failures++; $display("FAIL save_leds got=%h exp=%h", leds(), exp); end
        end
        checks++; if (bus.rec_count !== 3'd1 || bus.rec_index !== 2'd0) begin failures++; $display("FAIL save_count_index got=%0d/%0d exp=1/0", bus.rec_count, bus.rec_index); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL save_busy_drop got=%b exp=0", bus.busy); end
        $display("test_single_save done leds=%h", leds());
    endtask

    task automatic test_timeout();
        for (int f = 0; f < 3; f++) begin
            bus.frame_start = 1'b1;
            step();
            bus.frame_start = 1'b0;
            if (f < 2) begin
                checks++; if (bus.has_record !== 1'b1) begin failures++; $display("FAIL timeout_early frame=%0d got=%b exp=1", f, bus.has_record); end
                step();
            end
        end
        checks++; if (bus.has_record !== 1'b0) begin failures++; $display("FAIL timeout_has_record got=%b exp=0", bus.has_record); end
        checks++; if (leds() !== 28'h0) begin failures++; $display("FAIL timeout_leds got=%h exp=0", leds()); end
        pulse_next();
        checks++; if (bus.has_record !== 1'b1 || bus.rec_index !== 2'd0) begin failures++; $display("FAIL idle_next got=%b/%0d exp=1/0", bus.has_record, bus.rec_index); end
        checks++; if (leds() !== model_slots[0]) begin failures++; $display("FAIL idle_next_leds got=%h exp=%h", leds(), model_slots[0]); end
        $display("test_timeout done");
    endtask

    task automatic test_clamp();
        logic [27:0] exp;
        drive_save(28'hC1C2F3A);
        step();
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 28'hFFFFFFF;
        checks++; if (leds() !== exp || exp !== 28'h9192939) begin failures++; $display("FAIL clamp_leds got=%h exp=%h", leds(), exp); end
        checks++; if (bus.rec_count !== 3'd2 || bus.rec_index !== 2'd1) begin failures++; $display("FAIL clamp_count_index got=%0d/%0d exp=2/1", bus.rec_count, bus.rec_index); end
        $display("test_clamp done leds=%h", leds());
    endtask

    task automatic test_ignore();
        logic [27:0] exp;
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        model_clear();
        checks++; if (bus.rec_count !== 3'd0 || bus.has_record !== 1'b0) begin failures++; $display("FAIL clear_state got=%0d/%b exp=0/0", bus.rec_count, bus.has_record); end
        pulse_next();
        checks++; if (bus.has_record !== 1'b0 || bus.rec_index !== 2'd0) begin failures++; $display("FAIL empty_next got=%b/%0d exp=0/0", bus.has_record, bus.rec_index); end
        drive_save(28'h1111111);
        bus.save_req = 1'b1;   // held into CAPTURE, must be ignored
        step();
        bus.save_req = 1'b0;
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 28'hFFFFFFF;
        checks++; if (leds() !== exp) begin failures++; $display("FAIL hold_leds got=%h exp=%h", leds(), exp); end
        step();
        step();
        checks++; if (bus.rec_count !== 3'd1 || bus.busy !== 1'b0 || bus.has_record !== 1'b1) begin failures++; $display("FAIL hold_count got=%0d/%b/%b exp=1/0/1", bus.rec_count, bus.busy, bus.has_record); end
        $display("test_ignore done count=%0d", bus.rec_count);
    endtask

    task automatic test_priority();
        set_digits(28'h5555555);
        bus.save_req = 1'b1;
        bus.clear_req = 1'b1;
        step();
        bus.save_req = 1'b0;
        bus.clear_req = 1'b0;
        model_clear();
        checks++; if (bus.has_record !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL prio_state got=%b/%b exp=0/0", bus.has_record, bus.busy); end
        checks++; if (bus.rec_count !== 3'd0 || bus.rec_index !== 2'd0) begin failures++; $display("FAIL prio_count got=%0d/%0d exp=0/0", bus.rec_count, bus.rec_index); end
        step();
        checks++; if (leds() !== 28'h0 || bus.rec_count !== 3'd0) begin failures++; $display("FAIL prio_leds got=%h/%0d exp=0/0", leds(), bus.rec_count); end
        $display("test_priority done");
    endtask

    task automatic test_wrap();
        logic [27:0] exp;
        for (int k = 1; k <= 5; k++) begin
            drive_save({7{4'(k)}});
            step();
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 28'hFFFFFFF;
            checks++; if (leds() !== exp || bus.rec_index !== 2'((k - 1) % 4)) begin failures++; $display("FAIL wrap_save k=%0d got=%h/%0d exp=%h/%0d", k, leds(), bus.rec_index, exp, (k - 1) % 4); end
            step();
        end
        checks++; if (bus.rec_count !== 3'd4 || leds() !== 28'h5555555) begin failures++; $display("FAIL wrap_slot0 got=%0d/%h exp=4/5555555", bus.rec_count, leds()); end
        for (int s = 0; s < 4; s++) begin
            int idx;
            idx = (3 - s) % 4;
            pulse_next();
            checks++; if (bus.rec_index !== 2'(idx) || leds() !== model_slots[idx]) begin failures++; $display("FAIL browse step=%0d got=%0d/%h exp=%0d/%h", s, bus.rec_index, leds(), idx, model_slots[idx]); end
            $display("browse step=%0d index=%0d leds=%h", s, bus.rec_index, leds());
        end
        drive_save(28'h6666666);
        step();
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 28'hFFFFFFF;
        checks++; if (bus.rec_index !== 2'd1 || leds() !== exp) begin failures++; $display("FAIL wrap_wrptr got=%0d/%h exp=1/%h", bus.rec_index, leds(), exp); end
        $display("test_wrap done");
    endtask

    task automatic test_short_browse();
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        model_clear();
        drive_save(28'h1234567);
        step();
        void'(sb_q.pop_front());
        drive_save(28'h7654321);
        step();
        void'(sb_q.pop_front());
        pulse_next();
        checks++; if (bus.rec_index !== 2'd0 || leds() !== model_slots[0]) begin failures++; $display("FAIL short_browse0 got=%0d/%h exp=0/%h", bus.rec_index, leds(), model_slots[0]); end
        pulse_next();
        checks++; if (bus.rec_index !== 2'd1 || leds() !== model_slots[1]) begin failures++; $display("FAIL short_browse_wrap got=%0d/%h exp=1/%h", bus.rec_index, leds(), model_slots[1]); end
        $display("test_short_browse done");
    endtask

    task automatic test_rst_mid_capture();
        drive_save(28'h2222222);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear();
        checks++; if (bus.rec_count !== 3'd0 || bus.has_record !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rst_capture got=%0d/%b/%b exp=0/0/0", bus.rec_count, bus.has_record, bus.busy); end
        pulse_next();
        checks++; if (bus.has_record !== 1'b0 || leds() !== 28'h0) begin failures++; $display("FAIL rst_capture_next got=%b/%h exp=0/0", bus.has_record, leds()); end
        $display("test_rst_mid_capture done");
    endtask

    initial begin
        bus.save_req = 1'b0;
        bus.next_req = 1'b0;
        bus.clear_req = 1'b0;
        bus.frame_start = 1'b0;
        set_digits(28'h0);
        model_clear();
        test_reset();
        test_single_save();
        test_timeout();
        test_clamp();
        test_ignore();
        test_priority();
        test_wrap();
        test_short_browse();
        test_rst_mid_capture();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
